// File: rtl/parity_rr_arbiter.sv
// Two-requester round-robin arbiter: captures one word, adds its even-parity bit,
// then holds the result until the consumer accepts it. Per-source acceptance counters.
module parity_rr_arbiter #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [DW-1:0] data0,
    input  logic          req1,
    input  logic [DW-1:0] data1,
    output logic          ack0,
    output logic          ack1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_parity,
    output logic          out_src,
    output logic          busy,
    output logic [7:0]    cnt0,
    output logic [7:0]    cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Even parity: the returned bit makes word plus parity hold an even number of ones.
    function automatic logic even_parity(input logic [DW-1:0] word);
        return ^word;
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_capture;
    logic          w_grant;
    logic          w_handshake;
    logic [DW-1:0] w_grant_data;

    logic          r_last;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          r_parity;
    logic          r_src;
    logic          r_busy;
    logic [7:0]    r_cnt0;
    logic [7:0]    r_cnt1;

    // Next-state, grant selection and handshake detection.
    always_comb begin
        w_state_nxt  = r_state;
        w_capture    = 1'b0;
        w_grant      = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    w_capture   = 1'b1;
                    // r_last==1 means requester 1 went last, so requester 0 wins contention.
                    w_grant     = (req0 && req1) ? ~r_last : req1;
                    w_state_nxt = ST_CALC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CALC: begin
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_valid && out_ready) begin
                    w_handshake = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_grant_data = w_grant ? data1 : data0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: capture, parity, valid/ack pulses, busy and acceptance counters.
    // out_valid rises on the first HOLD edge so the result appears two edges after capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= 1'b1;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= {DW{1'b0}};
            r_parity <= 1'b0;
            r_src    <= 1'b0;
            r_busy   <= 1'b0;
            r_cnt0   <= 8'd0;
            r_cnt1   <= 8'd0;
        end else begin
            r_ack0 <= w_capture & ~w_grant;
            r_ack1 <= w_capture &  w_grant;
            r_busy <= (w_state_nxt != ST_IDLE);
            if (w_capture) begin
                r_data <= w_grant_data;
                r_src  <= w_grant;
                r_last <= w_grant;
            end
            if (r_state == ST_CALC) begin
                r_parity <= even_parity(r_data);
            end
            if (w_handshake) begin
                r_valid <= 1'b0;
            end else if (r_state == ST_HOLD) begin
                r_valid <= 1'b1;
            end
            if (w_handshake && !r_src) begin
                r_cnt0 <= r_cnt0 + 8'd1;
            end
            if (w_handshake && r_src) begin
                r_cnt1 <= r_cnt1 + 8'd1;
            end
        end
    end

    assign ack0       = r_ack0;
    assign ack1       = r_ack1;
    assign out_valid  = r_valid;
    assign out_data   = r_data;
    assign out_parity = r_parity;
    assign out_src    = r_src;
    assign busy       = r_busy;
    assign cnt0       = r_cnt0;
    assign cnt1       = r_cnt1;

endmodule

// File: tb/tb_parity_rr_arbiter.sv
// Directed self-checking bench for parity_rr_arbiter: latency, round-robin,
// backpressure, reset mid-transaction and counter wrap.
module tb_parity_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       ack0, ack1;
    logic       out_valid, out_ready;
    logic [7:0] out_data;
    logic       out_parity, out_src, busy;
    logic [7:0] cnt0, cnt1;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] m_cnt0, m_cnt1;

    always #5 clk = ~clk;

    parity_rr_arbiter #(.DW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .ack0(ack0), .ack1(ack1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_parity(out_parity), .out_src(out_src),
        .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ack0"},   ack0, 0);
        check_eq({tag, "_ack1"},   ack1, 0);
        check_eq({tag, "_valid"},  out_valid, 0);
        check_eq({tag, "_data"},   out_data, 0);
        check_eq({tag, "_parity"}, out_parity, 0);
        check_eq({tag, "_src"},    out_src, 0);
        check_eq({tag, "_busy"},   busy, 0);
        check_eq({tag, "_cnt0"},   cnt0, 0);
        check_eq({tag, "_cnt1"},   cnt1, 0);
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0;
        #1;
        check_all_zero(tag);
        m_cnt0 = 8'd0;
        m_cnt1 = 8'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One full transaction with fixed-latency checks; stall = cycles of out_ready=0 in HOLD.
    task automatic run_txn(input logic rq0, input logic rq1, input logic [7:0] d0, input logic [7:0] d1,
                           input logic exp_src, input logic [7:0] exp_data, input logic exp_par,
                           input int stall);
        req0 = rq0; req1 = rq1; data0 = d0; data1 = d1;
        out_ready = (stall == 0);
        tick();
        check_eq("ack0", ack0, !exp_src);
        check_eq("ack1", ack1, exp_src);
        check_eq("busy_calc", busy, 1);
        check_eq("valid_n0", out_valid, 0);
        if (exp_src) req1 = 1'b0; else req0 = 1'b0;
        tick();
        check_eq("ack_pulse", {ack0, ack1}, 0);
        check_eq("valid_n1", out_valid, 0);
        tick();
        check_eq("valid_n2", out_valid, 1);
        check_eq("out_data", out_data, exp_data);
        check_eq("out_parity", out_parity, exp_par);
        check_eq("out_src", out_src, exp_src);
        for (int i = 0; i < stall; i++) begin
            tick();
            check_eq("bp_valid", out_valid, 1);
            check_eq("bp_data", out_data, exp_data);
            check_eq("bp_parity", out_parity, exp_par);
            check_eq("bp_src", out_src, exp_src);
            check_eq("bp_ack", {ack0, ack1}, 0);
            check_eq("bp_busy", busy, 1);
        end
        out_ready = 1'b1;
        tick();
        if (exp_src) m_cnt1 = m_cnt1 + 8'd1; else m_cnt0 = m_cnt0 + 8'd1;
        check_eq("valid_done", out_valid, 0);
        check_eq("busy_done", busy, 0);
        check_eq("cnt0", cnt0, m_cnt0);
        check_eq("cnt1", cnt1, m_cnt1);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        data0 = 8'h00; data1 = 8'h00; out_ready = 1'b0;
        apply_reset("por");

        // Contention straight after reset: requester 0 first.
        run_txn(1'b1, 1'b1, 8'hF0, 8'h07, 1'b0, 8'hF0, 1'b0, 0);
        run_txn(1'b0, 1'b1, 8'hF0, 8'h07, 1'b1, 8'h07, 1'b1, 0);

        // Fairness over 8 transactions with both requests held.
        apply_reset("rst_fair");
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) run_txn(1'b1, 1'b1, 8'h0F, 8'h01, 1'b0, 8'h0F, 1'b0, 0);
            else            run_txn(1'b1, 1'b1, 8'h0F, 8'h01, 1'b1, 8'h01, 1'b1, 0);
        end
        check_eq("fair_cnt0", cnt0, 4);
        check_eq("fair_cnt1", cnt1, 4);

        // Single request with 5 cycles of backpressure.
        run_txn(1'b1, 1'b0, 8'hA8, 8'h00, 1'b0, 8'hA8, 1'b1, 5);
        check_eq("single_cnt0", cnt0, 5);

        // Reset while the result is held.
        req0 = 1'b1; data0 = 8'h3C;
        tick();
        req0 = 1'b0;
        tick();
        tick();
        check_eq("pre_rst_valid", out_valid, 1);
        apply_reset("rst_hold");
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("post_rst_ack", {ack0, ack1}, 0);
            check_eq("post_rst_valid", out_valid, 0);
            check_eq("post_rst_busy", busy, 0);
        end
        run_txn(1'b1, 1'b1, 8'h55, 8'hAA, 1'b0, 8'h55, 1'b0, 0);

        // 256 accepted requester-1 results wrap cnt1.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] d;
            d = 8'(i);
            run_txn(1'b0, 1'b1, 8'h00, d, 1'b1, d, ^d, 0);
        end
        check_eq("wrap_cnt1", cnt1, 0);
        check_eq("wrap_cnt0", cnt0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/parity_rr_arbiter.md
PARITY_RR_ARBITER -- requirements
Module: parity_rr_arbiter

Interface
REQ-001 SHALL have parameter DW, default 8: data width of each requester byte and of out_data.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port req0, input, 1: requester 0 has a word pending.
REQ-005 SHALL have port data0, input, DW: requester 0 word.
REQ-006 SHALL have port req1, input, 1: requester 1 has a word pending.
REQ-007 SHALL have port data1, input, DW: requester 1 word.
REQ-008 SHALL have port ack0, output, 1: registered one-cycle pulse; requester 0 word captured.
REQ-009 SHALL have port ack1, output, 1: registered one-cycle pulse; requester 1 word captured.
REQ-010 SHALL have port out_valid, output, 1: result available.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-012 SHALL have port out_data, output, DW: captured word.
REQ-013 SHALL have port out_parity, output, 1: even-parity bit of out_data.
REQ-014 SHALL have port out_src, output, 1: index of the requester that supplied out_data.
REQ-015 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-016 SHALL have ports cnt0 and cnt1, output, 8 each: results accepted per source; wrap 255->0.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, CALC, HOLD.
REQ-018 SHALL, in IDLE with no request asserted, remain in IDLE.
REQ-019 SHALL, in IDLE with at least one request asserted, capture the granted data and source, pulse the matching ack for exactly one cycle, and enter CALC.
REQ-020 SHALL grant round-robin: with both requests asserted, grant the requester not granted last; with one request asserted, grant that requester.
REQ-021 SHALL update the last-grant pointer at capture time in IDLE.
REQ-022 SHALL, in CALC, register out_parity equal to the XOR reduction of the captured word, so that word plus parity holds an even number of ones, and enter HOLD.
REQ-023 SHALL, in HOLD, hold out_valid high with out_data, out_parity and out_src stable until out_valid and out_ready are both high on a clock edge.
REQ-024 SHALL, on that handshake edge, deassert out_valid, increment cnt0 or cnt1 according to out_src, and return to IDLE.
REQ-025 SHALL give a fixed latency: request sampled at edge N gives ack high after edge N, out_valid high after edge N+2, and the earliest next capture at edge N+4 when out_ready is held high.
REQ-026 SHALL not sample req0 or req1 outside IDLE; requesters hold req and data until ack and drop req in the ack cycle.
REQ-027 SHALL ignore out_ready outside HOLD.
REQ-028 SHALL never assert ack0 and ack1 in the same cycle.

Reset
REQ-029 SHALL, while rst_n is low, force state to IDLE, set last-grant to 1 so requester 0 wins the first contention, and drive all outputs to 0: ack0, ack1, out_valid, out_data, out_parity, out_src, busy, cnt0 and cnt1.
REQ-030 SHALL, on reset asserted mid-transaction in any state, discard the pending word and raise no ack or out_valid after release until a new request is sampled in IDLE.

Verification
REQ-031 Single request: req0=1, data0=8'hA8 -> ack0 pulse, out_valid after 2 cycles, out_data=8'hA8, out_parity=1, out_src=0, and cnt0=1 after the handshake.
REQ-032 Contention after reset: req0=req1=1, data0=8'hF0, data1=8'h07 -> req0 is served first (parity 0), then req1 (parity 1); acks are never simultaneous.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_valid stays 1 with outputs stable, no new ack, and busy=1; then out_ready=1 -> single acceptance.
REQ-034 Fairness: both requests held continuously for 8 transactions -> out_src alternates 0,1,0,1,... and cnt0=cnt1=4.
REQ-035 Reset mid-HOLD: assert rst_n=0 while out_valid=1 -> all outputs 0 immediately, state IDLE, and the first grant after release goes to req0 under contention.
REQ-036 Counter wrap: 256 accepted requester-1 results -> cnt1 returns to 0 and cnt0 is unchanged.
